// File: rtl/lcm_pkg.sv
// Shared types and constants for the LCM stream capture receiver.
package lcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CAPTURE = 2'd2
  } lcm_state_e;

  // Number of byte lanes in one capture word.
  function automatic int lcm_lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  localparam int LCM_LANES = lcm_lanes(32, 8);

endpackage

// File: rtl/lcm_sync_edge.sv
// 2-FF synchronizer for one asynchronous panel signal, with registered
// rise/fall pulses. o_level is aligned with the pulses so a qualifier
// (e.g. DIN) read alongside an LP fall reflects the same pin instant.
module lcm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_d, r_rise, r_fall;

  // Synchronize, keep previous sample, register edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_d    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_d    <= r_s2;
      r_rise <= r_s2 & ~r_d;
      r_fall <= r_d & ~r_s2;
    end
  end

  assign o_level = r_d;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/lcm_stream_capture.sv
// Panel-side receiver for the LCM DIN/LP/XSCL/DATA stream: finds frame
// starts, packs bytes into capture words and reports per-frame statistics.
module lcm_stream_capture
  import lcm_pkg::*;
#(
  parameter int BYTE_WIDTH         = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clear,
  input  logic                            lcm_din,
  input  logic                            lcm_lp,
  input  logic                            lcm_xscl,
  input  logic [BYTE_WIDTH-1:0]           lcm_data,
  output logic                            cap_wen,
  output logic [OPT_MEM_ADDR_BITS-1:0]    cap_waddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cap_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] cap_wstrb,
  output logic [CNT_WIDTH-1:0]            line_bytes,
  output logic [CNT_WIDTH-1:0]            frame_lines,
  output logic [CNT_WIDTH-1:0]            frame_sum,
  output logic                            frame_done,
  output logic                            err_line_len,
  output logic                            err_overflow
);

  localparam int LANES = lcm_lanes(C_S_AXI_DATA_WIDTH, BYTE_WIDTH);
  localparam int LW    = $clog2(LANES);
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;

  logic w_din_lvl, w_din_rise, w_din_fall;
  logic w_lp_lvl, w_lp_rise, w_lp_fall;
  logic w_xscl_lvl, w_xscl_rise, w_xscl_fall;
  logic w_unused_ok;

  lcm_sync_edge u_din  (.clk(clk), .rst_n(rst_n), .i_async(lcm_din),
                        .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall));
  lcm_sync_edge u_lp   (.clk(clk), .rst_n(rst_n), .i_async(lcm_lp),
                        .o_level(w_lp_lvl), .o_rise(w_lp_rise), .o_fall(w_lp_fall));
  lcm_sync_edge u_xscl (.clk(clk), .rst_n(rst_n), .i_async(lcm_xscl),
                        .o_level(w_xscl_lvl), .o_rise(w_xscl_rise), .o_fall(w_xscl_fall));

  assign w_unused_ok = ^{w_din_rise, w_din_fall, w_lp_lvl, w_lp_rise, w_xscl_lvl, w_xscl_rise};

  // Data bus: plain 2-FF sync plus one stage to line up with the edge pulses.
  logic [BYTE_WIDTH-1:0] r_data_s1, r_data_s2, r_data_d;

  // Synchronize the pixel byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      r_data_d  <= '0;
    end else begin
      r_data_s1 <= lcm_data;
      r_data_s2 <= r_data_s1;
      r_data_d  <= r_data_s2;
    end
  end

  lcm_state_e                    r_state;
  logic [LW-1:0]                 r_lane;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_word;
  logic [SW-1:0]                 r_strb;
  logic [OPT_MEM_ADDR_BITS-1:0]  r_addr;
  logic                          r_wr_block;
  logic [CNT_WIDTH-1:0]          r_byte_cnt, r_line_cnt, r_sum, r_ref;

  logic [C_S_AXI_DATA_WIDTH-1:0] w_word_nx;
  logic [SW-1:0]                 w_strb_nx;
  logic                          w_full, w_wr;
  logic [CNT_WIDTH-1:0]          w_line_bytes, w_sum_nx;

  // Word/strobe as they look after this cycle's byte (if any) is merged;
  // a byte coinciding with LP is thereby flushed with the ending line.
  always_comb begin
    w_word_nx = r_word;
    w_strb_nx = r_strb;
    if (w_xscl_fall) begin
      w_word_nx[int'(r_lane)*BYTE_WIDTH +: BYTE_WIDTH] = r_data_d;
      w_strb_nx[r_lane] = 1'b1;
    end
  end

  assign w_full       = w_xscl_fall && (r_lane == LW'(LANES-1));
  assign w_wr         = w_full || (w_lp_fall && (w_strb_nx != '0));
  assign w_line_bytes = r_byte_cnt + CNT_WIDTH'(w_xscl_fall);
  assign w_sum_nx     = w_xscl_fall ? r_sum + CNT_WIDTH'(r_data_d) : r_sum;

  // Frame FSM with packing, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_word       <= '0;
      r_strb       <= '0;
      r_addr       <= '0;
      r_wr_block   <= 1'b0;
      r_byte_cnt   <= '0;
      r_line_cnt   <= '0;
      r_sum        <= '0;
      r_ref        <= '0;
      cap_wen      <= 1'b0;
      cap_waddr    <= '0;
      cap_wdata    <= '0;
      cap_wstrb    <= '0;
      line_bytes   <= '0;
      frame_lines  <= '0;
      frame_sum    <= '0;
      frame_done   <= 1'b0;
      err_line_len <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      cap_wen    <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        err_line_len <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (!enable) begin
        r_state <= ST_IDLE;
      end else if (clear) begin
        r_state <= ST_SEARCH;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_SEARCH;
          ST_SEARCH: begin
            if (w_lp_fall && w_din_lvl) begin
              r_state    <= ST_CAPTURE;
              r_lane     <= '0;
              r_word     <= '0;
              r_strb     <= '0;
              r_addr     <= '0;
              r_wr_block <= 1'b0;
              r_byte_cnt <= '0;
              r_line_cnt <= '0;
              r_sum      <= '0;
              r_ref      <= '0;
            end
          end
          ST_CAPTURE: begin
            // Word issue: full word or end-of-line flush of pending lanes.
            if (w_wr) begin
              r_word <= '0;
              r_strb <= '0;
              if (!r_wr_block) begin
                cap_wen   <= 1'b1;
                cap_waddr <= r_addr;
                cap_wdata <= w_word_nx;
                cap_wstrb <= w_strb_nx;
                if (r_addr == '1) r_wr_block <= 1'b1;
                else              r_addr     <= r_addr + OPT_MEM_ADDR_BITS'(1);
              end else begin
                err_overflow <= 1'b1;
              end
            end else begin
              r_word <= w_word_nx;
              r_strb <= w_strb_nx;
            end
            if (w_xscl_fall) r_lane <= r_lane + LW'(1);
            r_sum      <= w_sum_nx;
            r_byte_cnt <= w_line_bytes;
            // End of line; with DIN high also end of frame.
            if (w_lp_fall) begin
              r_lane     <= '0;
              r_byte_cnt <= '0;
              r_line_cnt <= r_line_cnt + CNT_WIDTH'(1);
              if (r_line_cnt == '0)              r_ref        <= w_line_bytes;
              else if (w_line_bytes != r_ref)    err_line_len <= 1'b1;
              if (w_din_lvl) begin
                line_bytes  <= (r_line_cnt == '0) ? w_line_bytes : r_ref;
                frame_lines <= r_line_cnt + CNT_WIDTH'(1);
                frame_sum   <= w_sum_nx;
                frame_done  <= 1'b1;
                r_line_cnt  <= '0;
                r_sum       <= '0;
                r_addr      <= '0;
                r_wr_block  <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcm_stream_capture.sv
// Scoreboard bench for lcm_stream_capture: directed panel streams, expected
// writes/frames queued up front, a negedge monitor pops and compares.
module tb_lcm_stream_capture;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct packed {
    logic [15:0] lb;
    logic [15:0] fl;
    logic [15:0] fs;
  } fr_t;

  logic clk = 1'b0;
  logic rst_n, en_a, en_s, clr, din, lp, xscl;
  logic [7:0] data;

  logic        a_wen, a_fd, a_el, a_eo;
  logic [9:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [15:0] a_lb, a_fl, a_fs;

  logic        s_wen, s_fd, s_el, s_eo;
  logic [1:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [15:0] s_lb, s_fl, s_fs;

  wr_t qa_wr[$], qs_wr[$];
  fr_t qa_fr[$], qs_fr[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lcm_stream_capture dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .clear(clr),
    .lcm_din(din), .lcm_lp(lp), .lcm_xscl(xscl), .lcm_data(data),
    .cap_wen(a_wen), .cap_waddr(a_waddr), .cap_wdata(a_wdata), .cap_wstrb(a_wstrb),
    .line_bytes(a_lb), .frame_lines(a_fl), .frame_sum(a_fs), .frame_done(a_fd),
    .err_line_len(a_el), .err_overflow(a_eo)
  );

  lcm_stream_capture #(.OPT_MEM_ADDR_BITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .clear(clr),
    .lcm_din(din), .lcm_lp(lp), .lcm_xscl(xscl), .lcm_data(data),
    .cap_wen(s_wen), .cap_waddr(s_waddr), .cap_wdata(s_wdata), .cap_wstrb(s_wstrb),
    .line_bytes(s_lb), .frame_lines(s_fl), .frame_sum(s_fs), .frame_done(s_fd),
    .err_line_len(s_el), .err_overflow(s_eo)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Monitor: every DUT write / frame_done must match the head of its queue.
  always @(negedge clk) begin
    if (a_wen) begin
      if (qa_wr.size() == 0) fail("a_write_unexpected");
      else chk("a_write", {a_waddr, a_wdata, a_wstrb}, qa_wr.pop_front());
    end
    if (a_fd) begin
      if (qa_fr.size() == 0) fail("a_frame_unexpected");
      else chk("a_frame", {a_lb, a_fl, a_fs}, qa_fr.pop_front());
    end
    if (s_wen) begin
      if (qs_wr.size() == 0) fail("s_write_unexpected");
      else chk("s_write", {8'h00, s_waddr, s_wdata, s_wstrb}, qs_wr.pop_front());
    end
    if (s_fd) begin
      if (qs_fr.size() == 0) fail("s_frame_unexpected");
      else chk("s_frame", {s_lb, s_fl, s_fs}, qs_fr.pop_front());
    end
  end

  task automatic pw_a(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    qa_wr.push_back({a, d, s});
  endtask
  task automatic pf_a(input logic [15:0] lb, input logic [15:0] fl, input logic [15:0] fs);
    qa_fr.push_back({lb, fl, fs});
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b; xscl = 1'b1;
    repeat (3) @(negedge clk);
    xscl = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_lp(input logic d);
    din = d; lp = 1'b1;
    repeat (3) @(negedge clk);
    lp = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b0;
  endtask

  // Byte and LP falling on the same clock.
  task automatic send_byte_lp(input logic [7:0] b, input logic d);
    data = b; din = d; xscl = 1'b1; lp = 1'b1;
    repeat (3) @(negedge clk);
    xscl = 1'b0; lp = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en_a = 1'b0; en_s = 1'b0; clr = 1'b0;
    din = 1'b0; lp = 1'b0; xscl = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_a", {a_wen, a_waddr, a_wdata, a_wstrb, a_lb, a_fl, a_fs, a_fd, a_el, a_eo}, '0);
    chk("reset_s", {s_wen, s_waddr, s_wdata, s_wstrb, s_lb, s_fl, s_fs, s_fd, s_el, s_eo}, '0);
    rst_n = 1'b1; en_a = 1'b1;
    repeat (2) @(negedge clk);

    // T1: 3 lines x 8 bytes 0x01..0x18, closed by a DIN line.
    pw_a(0, 32'h04030201, 4'hF); pw_a(1, 32'h08070605, 4'hF);
    pw_a(2, 32'h0C0B0A09, 4'hF); pw_a(3, 32'h100F0E0D, 4'hF);
    pw_a(4, 32'h14131211, 4'hF); pw_a(5, 32'h18171615, 4'hF);
    pf_a(16'd8, 16'd3, 16'h012C);
    send_lp(1'b1);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) send_byte(8'(l*8 + i + 1));
      send_lp(l == 2);
    end
    chk("t1_err_len", a_el, 1'b0);

    // T2: 5-byte line then 1-byte closing line; partial flushes.
    pw_a(0, 32'hA3A2A1A0, 4'hF); pw_a(1, 32'h000000A4, 4'h1);
    pw_a(2, 32'h00000055, 4'h1);
    pf_a(16'd5, 16'd2, 16'h037F);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    send_lp(1'b0);
    send_byte(8'h55);
    send_lp(1'b1);
    chk("t2_err_len_set", a_el, 1'b1);
    pulse_clear();
    chk("t2_err_len_clr", a_el, 1'b0);

    // T3: line lengths 8, 8, 6 then an empty closing line.
    pw_a(0, 32'h13121110, 4'hF); pw_a(1, 32'h17161514, 4'hF);
    pw_a(2, 32'h23222120, 4'hF); pw_a(3, 32'h27262524, 4'hF);
    pw_a(4, 32'h33323130, 4'hF); pw_a(5, 32'h00003534, 4'h3);
    pf_a(16'd8, 16'd4, 16'h02E7);
    send_lp(1'b1);
    for (int l = 1; l <= 3; l++) begin
      for (int i = 0; i < ((l == 3) ? 6 : 8); i++) send_byte(8'(l*16 + i));
      send_lp(1'b0);
      chk("t3_err_len", a_el, (l == 3));
    end
    send_lp(1'b1);
    chk("t3_err_len_sticky", a_el, 1'b1);
    pulse_clear();
    chk("t3_err_len_clr", a_el, 1'b0);

    // T4: byte 8 coincident with a frame-ending LP.
    pw_a(0, 32'h44434241, 4'hF); pw_a(1, 32'h48474645, 4'hF);
    pf_a(16'd8, 16'd1, 16'h0224);
    send_lp(1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'h41 + 8'(i));
    send_byte_lp(8'h48, 1'b1);
    chk("t4_line_bytes", a_lb, 16'd8);

    // T5: 4-word capture space, 5 words in one frame.
    en_a = 1'b0; en_s = 1'b1;
    qs_wr.push_back({10'd0, 32'h04030201, 4'hF});
    qs_wr.push_back({10'd1, 32'h08070605, 4'hF});
    qs_wr.push_back({10'd2, 32'h0C0B0A09, 4'hF});
    qs_wr.push_back({10'd3, 32'h100F0E0D, 4'hF});
    qs_fr.push_back({16'd20, 16'd1, 16'h00D2});
    @(negedge clk);
    send_lp(1'b1);
    for (int i = 1; i <= 20; i++) begin
      send_byte(8'(i));
      if (i == 16) chk("t5_ovf_after_last_addr", s_eo, 1'b0);
    end
    send_lp(1'b1);
    chk("t5_ovf_set", s_eo, 1'b1);
    chk("t5_a_ovf_clear", a_eo, 1'b0);

    // T6: enable dropped mid-frame, then reset mid-line.
    en_s = 1'b0; en_a = 1'b1;
    repeat (2) @(negedge clk);
    send_lp(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_hold_line_bytes", a_lb, 16'd8);
    en_a = 1'b1;
    send_byte(8'hE8); send_byte(8'hE9);
    send_lp(1'b0);
    send_byte(8'hF0); send_byte(8'hF1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_a", {a_wen, a_waddr, a_wdata, a_wstrb, a_lb, a_fl, a_fs, a_fd, a_el, a_eo}, '0);
    chk("t6_reset_s", {s_wen, s_waddr, s_wdata, s_wstrb, s_lb, s_fl, s_fs, s_fd, s_el, s_eo}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'hF2 + 8'(i));
    send_lp(1'b0);
    pw_a(0, 32'h64636261, 4'hF);
    pf_a(16'd4, 16'd1, 16'h018A);
    send_lp(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i));
    send_lp(1'b1);

    repeat (20) @(negedge clk);
    chk("queues_drained", qa_wr.size() + qa_fr.size() + qs_wr.size() + qs_fr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
